// File: rtl/ps2_pkg.sv
// Shared constants, event layout and receiver state encoding for the PS/2 keyboard path.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

    // Event word layout: {brk, ext, code[7:0]}
    localparam int unsigned EVT_W   = 10;
    localparam int unsigned EVT_BRK = 9;
    localparam int unsigned EVT_EXT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // PS/2 uses odd parity over data + parity bit
    function automatic logic odd_weight(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through synchronous FIFO for keyboard events.
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer, occupancy and storage next-state; pointers wrap naturally at Depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: synchroniser, clock glitch filter, frame deserialiser,
// E0/F0 prefix decoder and an event FIFO with valid/ready pop.
// Optional: define PS2_TYPEMATIC_FILTER_EN to drop repeated makes of the held key.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned KEEP_BREAK  = 1
) (
    input  logic                        clk_50mhz,
    input  logic                        reset_n,
    input  logic                        ps2c,
    input  logic                        ps2d,
    output logic [EVT_W-1:0]            evt_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  key_out,
    output logic                        overflow,
    output logic                        frame_err,
    input  logic                        clr_err
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]       c_sync_q, c_sync_d;
    logic [1:0]       d_sync_q, d_sync_d;
    logic             filt_q, filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             byte_stb_q, byte_stb_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic             push_q, push_d;
    logic             key_upd_q, key_upd_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [7:0]       key_out_q, key_out_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;

    logic ps2c_s;
    logic ps2d_s;
    logic bit_stb;
    logic rx_done;
    logic rx_err;
    logic ovf_set;
    logic fifo_full;
    logic fifo_empty;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       rpt_vld_q, rpt_vld_d;
    logic [8:0] rpt_q, rpt_d;
`endif

    assign ps2c_s = c_sync_q[1];
    assign ps2d_s = d_sync_q[1];

    // Two-flop synchronisers for the asynchronous PS/2 lines
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN equal samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (ps2c_s != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_d = ps2c_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        bit_stb = filt_q & ~filt_d;
    end

    // Frame deserialiser with inter-bit timeout
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        rx_done   = 1'b0;
        rx_err    = 1'b0;
        if (state_q == StIdle || bit_stb) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (bit_stb && !ps2d_s) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_stb) begin
                    shreg_d   = {ps2d_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (bit_stb) begin
                    par_d   = ps2d_s;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_stb) begin
                    state_d = StIdle;
                    if (ps2d_s && odd_weight({par_q, shreg_q})) begin
                        rx_done = 1'b1;
                    end else begin
                        rx_err = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && !bit_stb && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d = StIdle;
            rx_err  = 1'b1;
        end
        byte_stb_d = rx_done;
    end

    // Prefix decoder: folds E0/F0 into the next code and stages the event
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        push_d    = 1'b0;
        key_upd_d = 1'b0;
        evt_d     = evt_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
        rpt_vld_d = rpt_vld_q;
        rpt_d     = rpt_q;
`endif
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_stb_q) begin
            if (shreg_q == PS2_EXT_CODE) begin
                ext_d = 1'b1;
            end else if (shreg_q == PS2_BRK_CODE) begin
                brk_d = 1'b1;
            end else begin
                evt_d     = {brk_q, ext_q, shreg_q};
                key_upd_d = 1'b1;
                push_d    = !brk_q || (KEEP_BREAK != 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (brk_q) begin
                    rpt_vld_d = 1'b0;
                end else if (rpt_vld_q && rpt_q == {ext_q, shreg_q}) begin
                    push_d = 1'b0;
                end else begin
                    rpt_vld_d = 1'b1;
                    rpt_d     = {ext_q, shreg_q};
                end
`endif
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Push-cycle side effects: held-key register and sticky error flags
    always_comb begin
        key_out_d = key_out_q;
        if (key_upd_q) begin
            if (!evt_q[EVT_BRK]) begin
                key_out_d = evt_q[7:0];
            end else if (evt_q[7:0] == key_out_q) begin
                key_out_d = '0;
            end
        end
        ovf_set     = push_q & fifo_full & ~(evt_ready & ~fifo_empty);
        overflow_d  = clr_err ? 1'b0 : (overflow_q | ovf_set);
        frame_err_d = clr_err ? 1'b0 : (frame_err_q | rx_err);
    end

    // Receiver and decoder state registers
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            c_sync_q    <= 2'b11;
            d_sync_q    <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_stb_q  <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            key_upd_q   <= 1'b0;
            evt_q       <= '0;
            key_out_q   <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            c_sync_q    <= c_sync_d;
            d_sync_q    <= d_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_stb_q  <= byte_stb_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            key_upd_q   <= key_upd_d;
            evt_q       <= evt_d;
            key_out_q   <= key_out_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Last queued make, cleared by any break
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            rpt_vld_q <= 1'b0;
            rpt_q     <= '0;
        end else begin
            rpt_vld_q <= rpt_vld_d;
            rpt_q     <= rpt_d;
        end
    end
`endif

    ps2_evt_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EVT_W)
    ) u_fifo (
        .clk_i   (clk_50mhz),
        .rst_ni  (reset_n),
        .push_i  (push_q),
        .data_i  (evt_q),
        .pop_i   (evt_ready),
        .data_o  (evt_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign evt_valid = ~fifo_empty;
    assign key_out   = key_out_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Self-checking bench for ps2_key_fifo: directed scenarios plus a randomized byte
// stream, all checked against a queue-based keyboard event model.
module tb_ps2_key_fifo;

    localparam int DEPTH   = 8;
    localparam int HALF    = 50;   // PS/2 clock half period in system cycles
    localparam int QUARTER = 25;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2c;
    logic       ps2d;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] fifo_count;
    logic [7:0] key_out;
    logic       overflow;
    logic       frame_err;
    logic       clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [9:0] exp_q[$];
    logic       m_ext, m_brk, m_ovf, m_ferr;
    logic [7:0] m_key;
    logic       m_last_vld;
    logic [8:0] m_last;

    ps2_key_fifo #(
        .FILTER_LEN  (4),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (2000),
        .KEEP_BREAK  (1)
    ) dut (
        .clk_50mhz  (clk),
        .reset_n    (reset_n),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .evt_data   (evt_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .fifo_count (fifo_count),
        .key_out    (key_out),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #10 clk = ~clk;

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted before end of test");
        $fatal(1);
    end

    // ---------------- model ----------------
    task automatic model_reset();
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0; m_key = 8'h00;
        m_last_vld = 0; m_last = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic       do_push;
        logic [9:0] ev;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            ev = {m_brk, m_ext, b};
            if (!m_brk) m_key = b;
            else if (m_key == b) m_key = 8'h00;
            do_push = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (m_brk) m_last_vld = 0;
            else if (m_last_vld && m_last == {m_ext, b}) do_push = 0;
            else begin m_last_vld = 1; m_last = {m_ext, b}; end
`endif
            if (do_push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(ev);
                else m_ovf = 1;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_err();
        m_ferr = 1; m_ext = 0; m_brk = 0;
    endtask

    // ---------------- stimulus ----------------
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = f[i];
            repeat (QUARTER) @(negedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
            repeat (QUARTER) @(negedge clk);
        end
        ps2d = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
        model_byte(b);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b1), 11);
        model_err();
    endtask

    // Sends a full frame with a hand-driven stop bit; optionally pulses evt_ready
    // at negedge pop_at after the stop falling edge, and reports the first negedge
    // after that edge at which evt_valid is seen high.
    task automatic send_stop_custom(input logic [7:0] b, input int pop_at, output int lat);
        lat = 0;
        send_bits(mk_frame(b, 1'b0), 10);
        ps2d = 1'b1;
        repeat (QUARTER) @(negedge clk);
        ps2c = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            evt_ready = (k == pop_at);
            if (lat == 0 && evt_valid) lat = k;
        end
        evt_ready = 1'b0;
        ps2c = 1'b1;
        repeat (QUARTER) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovf = 0; m_ferr = 0;
        @(negedge clk);
    endtask

    // Pops everything the model expects, comparing each head word
    task automatic drain(input string name);
        int         n;
        logic [9:0] e;
        n = exp_q.size();
        n_checks++;
        if (fifo_count !== 4'(n)) begin
            n_fail++;
            $display("FAIL %s_count: got %0d expected %0d", name, fifo_count, n);
        end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (evt_valid !== 1'b1 || evt_data !== e) begin
                n_fail++;
                $display("FAIL %s_evt%0d: got valid=%b data=%h expected valid=1 data=%h",
                         name, i, evt_valid, evt_data, e);
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_empty: got valid=%b expected 0", name, evt_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        n_checks++; if (evt_data !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h expected 000", evt_data); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (key_out !== 8'h00) begin n_fail++; $display("FAIL reset_key: got %h expected 00", key_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    endtask

    task automatic test_single_make();
        int lat;
        send_stop_custom(8'h1D, 0, lat);
        model_byte(8'h1D);
        // 2 sync + FILTER_LEN filter cycles to the strobe, then 3 cycles to valid
        n_checks++; if (lat < 7 || lat > 10) begin n_fail++; $display("FAIL single_latency: got %0d expected 7..10", lat); end
        n_checks++; if (evt_data !== 10'h01D) begin n_fail++; $display("FAIL single_data: got %h expected 01D", evt_data); end
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        n_checks++; if (key_out !== 8'h1D) begin n_fail++; $display("FAIL single_key: got %h expected 1D", key_out); end
        drain("single");
    endtask

    task automatic test_ext_break();
        send_byte(8'hE0);
        send_byte(8'h75);
        n_checks++; if (key_out !== 8'h75) begin n_fail++; $display("FAIL ext_key_make: got %h expected 75", key_out); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_checks++; if (key_out !== 8'h00) begin n_fail++; $display("FAIL ext_key_break: got %h expected 00", key_out); end
        n_checks++; if (evt_data !== 10'h175) begin n_fail++; $display("FAIL ext_head: got %h expected 175", evt_data); end
        n_checks++; if (fifo_count !== 4'd2) begin n_fail++; $display("FAIL ext_count: got %0d expected 2", fifo_count); end
        drain("ext");
    endtask

    task automatic test_frame_err();
        send_byte(8'hF0);        // pending break prefix is discarded by the error
        send_bad(8'h2B);
        send_byte(8'h1C);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %b expected 1", frame_err); end
        n_checks++; if (evt_data !== 10'h01C) begin n_fail++; $display("FAIL perr_data: got %h expected 01C", evt_data); end
        drain("perr");
        pulse_clr();
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL perr_clr: got %b expected 0", frame_err); end
    endtask

    task automatic test_timeout();
        send_bits(mk_frame(8'h55, 1'b0), 5);   // start + 4 data bits
        repeat (200) @(negedge clk);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", frame_err); end
        repeat (2300) @(negedge clk);
        model_err();
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", frame_err); end
        pulse_clr();
        send_byte(8'h23);
        n_checks++; if (evt_data !== 10'h023) begin n_fail++; $display("FAIL tmo_next: got %h expected 023", evt_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_next_err: got %b expected 0", frame_err); end
        drain("tmo");
    endtask

    task automatic test_overflow();
        int lat;
        for (int i = 0; i <= DEPTH; i++) send_byte(8'h15 + 8'(i));
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        pulse_clr();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        // Pop on the push cycle while full: both happen, occupancy stays at 8
        send_stop_custom(8'h3A, 7, lat);
        void'(exp_q.pop_front());
        model_byte(8'h3A);
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_simul_count: got %0d expected 8", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_simul_flag: got %b expected 0", overflow); end
        drain("ovf");
    endtask

    task automatic test_glitch();
        ps2d = 1'b0;
        ps2c = 1'b0;
        repeat (2) @(negedge clk);
        ps2c = 1'b1;
        repeat (5) @(negedge clk);
        ps2d = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", evt_valid); end
        send_byte(8'h1B);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b expected 0", frame_err); end
        drain("glitch");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else b = 8'($urandom_range(1, 127));
            if ($urandom_range(0, 7) == 0) send_bad(b);
            else send_byte(b);
            n_checks++;
            if (key_out !== m_key) begin
                n_fail++;
                $display("FAIL rand_key%0d: got %h expected %h", i, key_out, m_key);
            end
        end
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf: got %b expected %b", overflow, m_ovf); end
        n_checks++; if (frame_err !== m_ferr) begin n_fail++; $display("FAIL rand_ferr: got %b expected %b", frame_err, m_ferr); end
        drain("rand");
        pulse_clr();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h2A);
        send_bits(mk_frame(8'h33, 1'b0), 4);
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", evt_valid); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        n_checks++; if (key_out !== 8'h00) begin n_fail++; $display("FAIL rst_key: got %h expected 00", key_out); end
        n_checks++; if (evt_data !== 10'h000) begin n_fail++; $display("FAIL rst_data: got %h expected 000", evt_data); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2500) @(negedge clk);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_no_tmo: got %b expected 0", frame_err); end
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_evt: got %b expected 0", evt_valid); end
        send_byte(8'h44);
        drain("rst");
    endtask

    initial begin
        evt_ready = 1'b0;
        clr_err   = 1'b0;
        ps2c      = 1'b1;
        ps2d      = 1'b1;
        reset_n   = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_single_make();
        test_ext_break();
        test_frame_err();
        test_timeout();
        test_overflow();
        test_glitch();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
